// File: rtl/gin_pkg.sv
// Shared types for the GIN multicast bus sender: packet struct, FSM state
// encoding and FIFO depth. XID_BITS sets the default tag/ID width.
`ifndef XID_BITS
`define XID_BITS 4
`endif

package gin_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int GIN_ID_W   = `XID_BITS;
  localparam int GIN_DATA_W = 32;

  typedef enum logic {
    CFG = 1'b0,
    RUN = 1'b1
  } gin_state_t;

  // Default packet layout; the top rebuilds it from its own parameters.
  typedef struct packed {
    logic [GIN_ID_W-1:0]   tag;
    logic [GIN_DATA_W-1:0] data;
  } gin_pkt_t;

endpackage

// File: rtl/gin_pkt_fifo.sv
// Two-entry packet FIFO with a registered head entry. Push and pop may occur
// in the same cycle, including while full. The head register feeds the bus
// directly, so nothing on the write side reaches the outputs combinationally.
module gin_pkt_fifo
  import gin_pkg::*;
#(
  parameter type pkt_t = gin_pkt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  pkt_t push_pkt,
  input  logic pop,
  output pkt_t head,
  output logic full,
  output logic empty
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] cnt_q;
  pkt_t             tail_q;
  logic             do_push;
  logic             do_pop;
  logic             one_q;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign one_q   = (cnt_q == CNT_W'(1));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Occupancy and head entry: head loads from the input when the new packet
  // becomes the oldest, otherwise it advances from the tail on a pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      head  <= '0;
    end else begin
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (do_push && (empty || (one_q && do_pop))) begin
        head <= push_pkt;
      end else if (do_pop && full) begin
        head <= tail_q;
      end
    end
  end

  // Second entry: written when the new packet queues behind a valid head.
  // NOTE: storage behind the head is not reset; cnt_q says whether it holds
  // anything, so its contents after reset never matter.
  always_ff @(posedge clk) begin
    if (do_push && ((one_q && !do_pop) || (full && do_pop))) begin
      tail_q <= push_pkt;
    end
  end

endmodule

// File: rtl/gin_bus_sender.sv
// Source end of the GIN multicast bus. In CFG it streams one ID per
// downstream controller using one-hot set_id strobes; in RUN it forwards
// packets from a 2-entry FIFO onto {bus_valid, bus_tag, bus_data}.
// Optional macro GIN_TIMEOUT_EN: drop a head packet that stalls for
// TIMEOUT_CYCLES cycles so an unmatched tag cannot deadlock the bus.
`ifndef XID_BITS
`define XID_BITS 4
`endif

module gin_bus_sender
  import gin_pkg::*;
#(
  parameter int ID_SIZE        = `XID_BITS,
  parameter int DATA_SIZE      = 32,
  parameter int NUM_TARGETS    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic [ID_SIZE-1:0]     cfg_id,
  output logic                   cfg_ready,
  output logic [NUM_TARGETS-1:0] set_id,
  output logic [ID_SIZE-1:0]     id_out,
  output logic                   cfg_done,
  input  logic                   in_valid,
  input  logic [ID_SIZE-1:0]     in_tag,
  input  logic [DATA_SIZE-1:0]   in_data,
  output logic                   in_ready,
  output logic                   bus_valid,
  output logic [ID_SIZE-1:0]     bus_tag,
  output logic [DATA_SIZE-1:0]   bus_data,
  input  logic                   bus_ready,
  output logic                   drop_pulse
);

  typedef struct packed {
    logic [ID_SIZE-1:0]   tag;
    logic [DATA_SIZE-1:0] data;
  } pkt_t;

  localparam int TGT_W = $clog2(NUM_TARGETS);

  if (NUM_TARGETS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("gin_bus_sender: NUM_TARGETS and TIMEOUT_CYCLES must be >= 2");
  end

  gin_state_t       state;
  logic [TGT_W-1:0] tgt_cnt;
  logic             cfg_pend;
  logic             run;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  pkt_t             in_pkt;
  pkt_t             head_pkt;

  assign run        = (state == RUN);
  assign cfg_ready  = !run;
  assign cfg_done   = run;
  assign bus_valid  = run && !fifo_empty;
  assign pop        = bus_valid && (bus_ready || drop);
  // A reconfigure request, new or pending, stops intake so the FIFO drains.
  assign in_ready   = run && !cfg_pend && !cfg_start && (!fifo_full || pop);
  assign push       = in_valid && in_ready;
  assign in_pkt     = '{tag: in_tag, data: in_data};
  assign bus_tag    = head_pkt.tag;
  assign bus_data   = head_pkt.data;
  assign drop_pulse = drop;

  gin_pkt_fifo #(
    .pkt_t (pkt_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_pkt (in_pkt),
    .pop      (pop),
    .head     (head_pkt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ID load strobe for the target currently being programmed.
  // NOTE: defaults come first so every path assigns both outputs and no
  // latch is inferred.
  always_comb begin
    set_id = '0;
    id_out = '0;
    if (cfg_ready && cfg_valid) begin
      set_id[tgt_cnt] = 1'b1;
      id_out          = cfg_id;
    end
  end

  // Mode FSM: count config words in CFG, handle reconfigure requests in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CFG;
      tgt_cnt  <= '0;
      cfg_pend <= 1'b0;
    end else begin
      case (state)
        CFG: begin
          if (cfg_valid) begin
            if (tgt_cnt == TGT_W'(NUM_TARGETS - 1)) begin
              tgt_cnt <= '0;
              state   <= RUN;
            end else begin
              tgt_cnt <= tgt_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if ((cfg_pend || cfg_start) && fifo_empty) begin
            state    <= CFG;
            tgt_cnt  <= '0;
            cfg_pend <= 1'b0;
          end else if (cfg_start) begin
            cfg_pend <= 1'b1;
          end
        end
        default: state <= CFG;
      endcase
    end
  end

`ifdef GIN_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

  logic [STALL_W-1:0] stall_cnt;

  assign drop = bus_valid && !bus_ready &&
                (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts stalled bus cycles, restarts on every pop or drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!bus_valid || pop) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

endmodule
